// File: rtl/interrupt_controller_pkg.sv
// Core-wide constants shared by the interrupt controller: FSM encoding and
// default vector table placement.
package interrupt_controller_pkg;

  // Controller states; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } ic_state_t;

  // Vector of source 0 and spacing between consecutive source vectors.
  localparam logic [15:0] DEF_VEC_BASE   = 16'hFF00;
  localparam logic [15:0] DEF_VEC_STRIDE = 16'h0010;

endpackage

// File: rtl/interrupt_controller_edge_detect.sv
// Per-source rising-edge detector with a sticky pending bit.
// A new edge and a clear on the same bit in the same cycle leaves the bit set,
// so an event arriving exactly at acknowledge time is never lost.
module irq_edge_detect #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [N_SRC-1:0] clr,
  output logic [N_SRC-1:0] pending
);

  logic [N_SRC-1:0] prev;

  // Sample the request lines and latch 0->1 transitions until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= src;
      pending <= (pending & ~clr) | (src & ~prev);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Prioritising interrupt controller for the 16-bit core. Latches rising-edge
// requests, picks the lowest unmasked pending index, raises `interrupt` with
// that source's vector and tracks the core's take/return so only one
// interrupt is ever in service.
//
// Handshake with the core: `interrupt` is held (with stable int_id and
// int_vector) until the core pulses `int_ack` for one cycle; the acknowledge
// drops the request, clears that source's pending bit and enters service.
// Service ends on a one-cycle `int_done` pulse. Pulses arriving in any other
// state are ignored.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [15:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [15:0] VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int         ID_W       = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             irq_mask_we,
  input  logic [N_SRC-1:0] irq_mask_wdata,
  input  logic             int_ack,
  input  logic             int_done,
  output logic             interrupt,
  output logic [15:0]      int_vector,
  output logic [ID_W-1:0]  int_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  ic_state_t        state, state_nxt;
  logic [N_SRC-1:0] mask, mask_eff, sel, clr;
  logic [ID_W-1:0]  win_id, id_nxt;
  logic             win_valid;
  logic [15:0]      win_vec, vec_nxt;
  logic             int_nxt, serv_nxt;

  irq_edge_detect #(.N_SRC(N_SRC)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .src     (irq_src),
    .clr     (clr),
    .pending (pending)
  );

  // Mask register; resets to all sources masked.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '1;
    end else if (irq_mask_we) begin
      mask <= irq_mask_wdata;
    end
  end

  // A mask write already governs arbitration on the edge that samples it.
  assign mask_eff = irq_mask_we ? irq_mask_wdata : mask;
  assign sel      = pending & ~mask_eff;

  // Priority encoder: lowest set index wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (sel[i]) begin
        win_valid = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  // Vector address wraps modulo 2^16.
  assign win_vec = VEC_BASE + 16'(win_id) * VEC_STRIDE;

  // Next-state and next-output logic for the request/service sequence.
  always_comb begin
    state_nxt = state;
    int_nxt   = interrupt;
    serv_nxt  = in_service;
    id_nxt    = int_id;
    vec_nxt   = int_vector;
    clr       = '0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nxt = ST_REQ;
          int_nxt   = 1'b1;
          id_nxt    = win_id;
          vec_nxt   = win_vec;
        end
      end
      ST_REQ: begin
        // No re-arbitration here: the chosen source stays until taken.
        if (int_ack) begin
          clr       = N_SRC'(1) << int_id;
          int_nxt   = 1'b0;
          serv_nxt  = 1'b1;
          state_nxt = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (int_done) begin
          serv_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        int_nxt   = 1'b0;
        serv_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      interrupt  <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      int_vector <= VEC_BASE;
    end else begin
      state      <= state_nxt;
      interrupt  <= int_nxt;
      in_service <= serv_nxt;
      int_id     <= id_nxt;
      int_vector <= vec_nxt;
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus a randomized run
// against a behavioural reference model.
module tb_interrupt_controller;

  localparam int          N    = 4;
  localparam int          ID_W = $clog2(N);
  localparam logic [15:0] VB   = 16'hFF00;
  localparam logic [15:0] VS   = 16'h0010;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    irq_src;
  logic            irq_mask_we;
  logic [N-1:0]    irq_mask_wdata;
  logic            int_ack;
  logic            int_done;
  logic            interrupt;
  logic [15:0]     int_vector;
  logic [ID_W-1:0] int_id;
  logic [N-1:0]    pending;
  logic            in_service;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: events, mask, and whether a request or a
  // handler is outstanding.
  logic [N-1:0]    m_pend, m_prev, m_mask;
  logic            m_int, m_serv;
  logic [ID_W-1:0] m_id;
  logic [15:0]     m_vec;

  interrupt_controller #(.N_SRC(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .irq_mask_we    (irq_mask_we),
    .irq_mask_wdata (irq_mask_wdata),
    .int_ack        (int_ack),
    .int_done       (int_done),
    .interrupt      (interrupt),
    .int_vector     (int_vector),
    .int_id         (int_id),
    .pending        (pending),
    .in_service     (in_service)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Advance the model by one clock using the inputs seen at the edge.
  task automatic model_step();
    logic [N-1:0] rise, mnow, nxt_pend;
    int w;
    rise = irq_src & ~m_prev;
    mnow = irq_mask_we ? irq_mask_wdata : m_mask;
    if (reset) begin
      m_pend = '0; m_prev = '0; m_mask = '1;
      m_int = 1'b0; m_serv = 1'b0; m_id = '0; m_vec = VB;
    end else begin
      nxt_pend = m_pend | rise;
      if (m_int) begin
        if (int_ack) begin
          nxt_pend[m_id] = rise[m_id];
          m_int  = 1'b0;
          m_serv = 1'b1;
        end
      end else if (m_serv) begin
        if (int_done) m_serv = 1'b0;
      end else begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && m_pend[i] && !mnow[i]) w = i;
        if (w >= 0) begin
          m_int = 1'b1;
          m_id  = ID_W'(w);
          m_vec = 16'((int'(VB) + w * int'(VS)) % 65536);
        end
      end
      m_pend = nxt_pend;
      m_prev = irq_src;
      m_mask = mnow;
    end
  endtask

  // One clock: edge, model update, then settle before sampling outputs.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1; cycle(); int_done = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    irq_mask_we = 1'b1; irq_mask_wdata = m; cycle(); irq_mask_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL reset_interrupt: got %b want 0", interrupt); end
    tests_run++; if (in_service !== 1'b0) begin tests_failed++; $display("FAIL reset_in_service: got %b want 0", in_service); end
    tests_run++; if (int_vector !== 16'hFF00) begin tests_failed++; $display("FAIL reset_vector: got %h want ff00", int_vector); end
    tests_run++; if (int_id !== 2'd0) begin tests_failed++; $display("FAIL reset_id: got %0d want 0", int_id); end
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending: got %b want 0000", pending); end
  endtask

  task automatic test_single();
    write_mask(4'b0000);
    irq_src = 4'b0100; cycle();
    tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL single_pending: got %b want 0100", pending); end
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL single_early_int: got %b want 0", interrupt); end
    cycle();
    tests_run++; if ({interrupt, int_id, int_vector} !== {1'b1, 2'd2, 16'hFF20}) begin tests_failed++; $display("FAIL single_request: got int=%b id=%0d vec=%h want int=1 id=2 vec=ff20", interrupt, int_id, int_vector); end
    pulse_ack();
    tests_run++; if ({interrupt, in_service, pending} !== {1'b0, 1'b1, 4'b0000}) begin tests_failed++; $display("FAIL single_ack: got int=%b svc=%b pend=%b want int=0 svc=1 pend=0000", interrupt, in_service, pending); end
    pulse_done();
    tests_run++; if ({interrupt, in_service} !== 2'b00) begin tests_failed++; $display("FAIL single_done: got int=%b svc=%b want 0 0", interrupt, in_service); end
    irq_src = 4'b0000; cycle();
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL single_idle: got %b want 0", interrupt); end
  endtask

  task automatic test_priority();
    irq_src = 4'b1010; cycle(); cycle();
    tests_run++; if ({interrupt, int_id, int_vector} !== {1'b1, 2'd1, 16'hFF10}) begin tests_failed++; $display("FAIL prio_first: got int=%b id=%0d vec=%h want int=1 id=1 vec=ff10", interrupt, int_id, int_vector); end
    irq_src = 4'b1011; cycle();
    tests_run++; if ({interrupt, int_id, pending} !== {1'b1, 2'd1, 4'b1011}) begin tests_failed++; $display("FAIL prio_no_preempt: got int=%b id=%0d pend=%b want int=1 id=1 pend=1011", interrupt, int_id, pending); end
    pulse_ack();
    tests_run++; if (pending !== 4'b1001) begin tests_failed++; $display("FAIL prio_clear: got %b want 1001", pending); end
    pulse_done();
    tests_run++; if (interrupt !== 1'b0) begin tests_failed++; $display("FAIL prio_gap: got %b want 0", interrupt); end
    cycle();
    tests_run++; if ({interrupt, int_id, int_vector} !== {1'b1, 2'd0, 16'hFF00}) begin tests_failed++; $display("FAIL prio_second: got int=%b id=%0d vec=%h want int=1 id=0 vec=ff00", interrupt, int_id, int_vector); end
    pulse_ack(); pulse_done(); cycle();
    tests_run++; if ({interrupt, int_id, int_vector} !== {1'b1, 2'd3, 16'hFF30}) begin tests_failed++; $display("FAIL prio_third: got int=%b id=%0d vec=%h want int=1 id=3 vec=ff30", interrupt, int_id, int_vector); end
    pulse_ack(); pulse_done();
    irq_src = 4'b0000; cycle();
  endtask

  task automatic test_mask();
    reset = 1'b1; cycle(); reset = 1'b0;
    irq_src = 4'b0001; cycle(); cycle(); cycle();
    tests_run++; if ({interrupt, pending} !== {1'b0, 4'b0001}) begin tests_failed++; $display("FAIL mask_blocked: got int=%b pend=%b want int=0 pend=0001", interrupt, pending); end
    write_mask(4'b0000);
    tests_run++; if ({interrupt, int_id} !== {1'b1, 2'd0}) begin tests_failed++; $display("FAIL mask_release: got int=%b id=%0d want int=1 id=0", interrupt, int_id); end
    pulse_ack(); pulse_done();
    irq_src = 4'b0000; cycle();
  endtask

  task automatic test_level_set_wins();
    irq_src = 4'b0010; cycle(); cycle();
    tests_run++; if ({interrupt, int_id} !== {1'b1, 2'd1}) begin tests_failed++; $display("FAIL level_req: got int=%b id=%0d want int=1 id=1", interrupt, int_id); end
    pulse_ack(); cycle(); cycle();
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL level_no_retrigger: got %b want 0000", pending); end
    pulse_done(); cycle(); cycle();
    tests_run++; if ({interrupt, in_service} !== 2'b00) begin tests_failed++; $display("FAIL level_single_event: got int=%b svc=%b want 0 0", interrupt, in_service); end
    irq_src = 4'b0100; cycle(); cycle();
    tests_run++; if ({interrupt, int_id} !== {1'b1, 2'd2}) begin tests_failed++; $display("FAIL setwin_req: got int=%b id=%0d want int=1 id=2", interrupt, int_id); end
    irq_src = 4'b0000; cycle();
    irq_src = 4'b0100; pulse_ack();
    tests_run++; if ({in_service, pending} !== {1'b1, 4'b0100}) begin tests_failed++; $display("FAIL setwin_pending: got svc=%b pend=%b want svc=1 pend=0100", in_service, pending); end
    pulse_done(); cycle();
    tests_run++; if ({interrupt, int_id} !== {1'b1, 2'd2}) begin tests_failed++; $display("FAIL setwin_rerequest: got int=%b id=%0d want int=1 id=2", interrupt, int_id); end
    pulse_ack(); pulse_done();
    irq_src = 4'b0000; cycle();
  endtask

  task automatic test_spurious();
    pulse_ack();
    tests_run++; if ({interrupt, in_service, pending} !== {2'b00, 4'b0000}) begin tests_failed++; $display("FAIL spur_ack_idle: got int=%b svc=%b pend=%b want 0 0 0000", interrupt, in_service, pending); end
    pulse_done();
    tests_run++; if ({interrupt, in_service, pending} !== {2'b00, 4'b0000}) begin tests_failed++; $display("FAIL spur_done_idle: got int=%b svc=%b pend=%b want 0 0 0000", interrupt, in_service, pending); end
    irq_src = 4'b1000; cycle(); cycle();
    pulse_done();
    tests_run++; if ({interrupt, in_service, int_id} !== {2'b10, 2'd3}) begin tests_failed++; $display("FAIL spur_done_req: got int=%b svc=%b id=%0d want 1 0 3", interrupt, in_service, int_id); end
    pulse_ack(); pulse_ack();
    tests_run++; if ({interrupt, in_service} !== 2'b01) begin tests_failed++; $display("FAIL spur_ack_service: got int=%b svc=%b want 0 1", interrupt, in_service); end
    pulse_done();
    irq_src = 4'b0000; cycle();
  endtask

  task automatic test_reset_mid();
    irq_src = 4'b0001; cycle(); cycle();
    pulse_ack();
    irq_src = 4'b1011; cycle();
    tests_run++; if ({in_service, pending} !== {1'b1, 4'b1010}) begin tests_failed++; $display("FAIL rstmid_setup: got svc=%b pend=%b want svc=1 pend=1010", in_service, pending); end
    reset = 1'b1; irq_src = 4'b0000; cycle(); reset = 1'b0;
    tests_run++; if ({interrupt, in_service, int_vector, int_id, pending} !== {2'b00, 16'hFF00, 2'd0, 4'b0000}) begin tests_failed++; $display("FAIL rstmid_values: got int=%b svc=%b vec=%h id=%0d pend=%b want 0 0 ff00 0 0000", interrupt, in_service, int_vector, int_id, pending); end
    irq_src = 4'b0001; cycle(); cycle(); cycle();
    tests_run++; if ({interrupt, pending} !== {1'b0, 4'b0001}) begin tests_failed++; $display("FAIL rstmid_mask: got int=%b pend=%b want int=0 pend=0001", interrupt, pending); end
    reset = 1'b1; irq_src = 4'b0000; cycle(); reset = 1'b0;
  endtask

  task automatic test_random();
    write_mask(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
      int_ack        = ($urandom_range(0, 2) == 0);
      int_done       = ($urandom_range(0, 2) == 0);
      irq_mask_we    = ($urandom_range(0, 15) == 0);
      irq_mask_wdata = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      reset          = ($urandom_range(0, 299) == 0);
      cycle();
      tests_run++;
      if ({interrupt, in_service, int_id, int_vector, pending} !== {m_int, m_serv, m_id, m_vec, m_pend}) begin
        tests_failed++;
        $display("FAIL random_cycle_%0d: got int=%b svc=%b id=%0d vec=%h pend=%b want int=%b svc=%b id=%0d vec=%h pend=%b",
                 c, interrupt, in_service, int_id, int_vector, pending, m_int, m_serv, m_id, m_vec, m_pend);
      end
    end
    int_ack = 1'b0; int_done = 1'b0; irq_mask_we = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; irq_mask_we = 1'b0; irq_mask_wdata = '0;
    int_ack = 1'b0; int_done = 1'b0;
    m_pend = '0; m_prev = '0; m_mask = '1; m_int = 1'b0; m_serv = 1'b0;
    m_id = '0; m_vec = VB;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_level_set_wins();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Prioritising interrupt source for the 16-bit pipelined core. It collects rising-edge requests from up to N_SRC peripherals and drives the core's single `interrupt` line with a vector address. It then tracks the core's take (`int_ack`) and return (`int_done`), so only one interrupt is in service at a time. The block drives the core's `interrupt` input; the jump control block consumes it and pulses the acknowledge and return strobes back.

## Interface
- `N_SRC`, 4: number of request sources, 2..8.
- `VEC_BASE`, 16'hFF00: vector address of source 0.
- `VEC_STRIDE`, 16'h0010: vector spacing per source index.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `irq_src`  in  N_SRC  peripheral request lines; rising-edge sensitive, already synchronous to `clk`.
- `irq_mask_we`  in  1  mask write strobe.
- `irq_mask_wdata`  in  N_SRC  new mask; 1 = source masked.
- `int_ack`  in  1  one-cycle pulse from core: vector taken.
- `int_done`  in  1  one-cycle pulse from core: return from interrupt.
- `interrupt`  out  1  request to core.
- `int_vector`  out  16  vector address of the requested or in-service source.
- `int_id`  out  clog2(N_SRC)  index of the requested or in-service source.
- `pending`  out  N_SRC  latched, not-yet-acknowledged events.
- `in_service`  out  1  core is executing a handler.

## Operation
- Reset values:
  - `interrupt`=0, `in_service`=0, `int_vector`=VEC_BASE, `int_id`=0, `pending`=0.
  - Mask = all ones (all masked).
  - Previous-sample register = 0, state IDLE.
- Edge detection: `pending[i]` is set at the edge where `irq_src[i]`=1 and the previous sample was 0. It is set regardless of mask. Level-high inputs do not re-trigger.
- Mask: a write takes effect from the edge on which `irq_mask_we` is sampled. Masking never clears `pending`.
- Selection: `sel = pending & ~mask`. The winner is the lowest set index (source 0 has the highest priority).
- State IDLE: if `sel`≠0, go to REQ. Latch `int_id`=winner and `int_vector`=VEC_BASE + winner*VEC_STRIDE (16-bit, wraps modulo 2^16). Set `interrupt`=1.
- State REQ: hold `interrupt`, `int_id` and `int_vector` stable, with no re-arbitration even if a higher-priority source arrives or the chosen source is masked. On `int_ack`:
  - clear `pending[int_id]`;
  - `interrupt`=0, `in_service`=1;
  - go to SERVICE.
- State SERVICE: new edges are still latched into `pending`. On `int_done`, set `in_service`=0 and go to IDLE. `int_id` and `int_vector` keep their last values.
- Illegal or unexpected inputs:
  - `int_ack` in IDLE or SERVICE is ignored.
  - `int_done` in IDLE or REQ is ignored.
  - Unused state encoding returns to IDLE.
- Simultaneous set and clear: if a new edge on `irq_src[int_id]` coincides with the `int_ack` clear, set wins and the bit stays pending.
- Reset mid-operation (any state): all state returns to the reset values on that edge and pending events are discarded.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Request latency:
  - Edge sampled at clock k → `pending` visible after k.
  - `interrupt` high after k+1, i.e. 2 cycles from the input edge to the request.
- `int_ack` sampled at edge a → `interrupt`=0 and `in_service`=1 after a.
- `int_done` sampled at edge d → IDLE after d. The earliest next `interrupt` is after d+1.
- Minimum spacing between handled interrupts: REQ 1 cycle, SERVICE 1 cycle, IDLE 1 cycle.

## Structure
- Shared package (core-wide constants package):
  - state encoding IDLE=2'b00, REQ=2'b01, SERVICE=2'b10;
  - default VEC_BASE and VEC_STRIDE.
- Sub-module `irq_edge_detect`: per-source previous-sample register and pending bit, with set/clear inputs. Instantiated once with width N_SRC.
- The top level holds the mask register, priority encoder, FSM and vector computation.

## Test plan
- Single request:
  - Stimulus: after reset, write mask=4'b0000, then raise `irq_src[2]` at edge k.
  - Required: `pending`=4'b0100 after k; `interrupt`=1 with `int_vector`=16'hFF20 and `int_id`=2 after k+1.
  - Then pulse `int_ack`: `interrupt`=0, `in_service`=1, `pending`=0. Then pulse `int_done`: IDLE, `in_service`=0.
- Priority and no pre-emption:
  - Stimulus: edges on sources 3 and 1 in the same cycle.
  - Required: request with id 1, vector 16'hFF10. Source 0 edge during REQ does not change id. After ack/done of id 1, the next request is id 0, then id 3.
- Mask:
  - Stimulus: reset (mask=all ones), edge on source 0.
  - Required: `pending`=4'b0001, `interrupt` stays 0. Write mask=0 → `interrupt`=1 one cycle later.
- Level hold and set-wins:
  - Held-high `irq_src[1]` produces exactly one pending event.
  - A new edge on the in-service source coincident with `int_ack` leaves `pending[id]`=1, and a second request follows after `int_done`.
- Spurious handshakes and reset:
  - `int_ack` and `int_done` pulses in IDLE cause no state change.
  - `reset` asserted while in SERVICE with pending=4'b1010 → all outputs at reset values on the next cycle.
